// File: rtl/clksw_pkg.sv
// rtl/clksw_pkg.sv - shared types, defaults and helpers for the phi2 clock-switch sequencer
// Purpose: FSM state enum, default parameter values, counter-width and
//          half-period helpers used by clk_switch_seq_m and its interface.
// Ports:   none (package).
package clksw_pkg;

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } clksw_state_e;

  localparam int CLKSW_SYNC_STAGES  = 2;
  localparam int CLKSW_DIV_LOG2_MAX = 3;
  localparam int CLKSW_DEADTIME     = 2;

  // Bits needed to hold 0..max_val (at least one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int clamp_exp(input int sel, input int max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction

  // HS half-period in hs_ck cycles for a divider exponent.
  function automatic int half_period(input int sel, input int max_log2);
    return 1 << clamp_exp(sel, max_log2);
  endfunction

endpackage

// File: rtl/clk_switch_seq_m_if.sv
// rtl/clk_switch_seq_m_if.sv - mode-request / CPU-clock bundle for the clock-switch sequencer
// Purpose: groups the decoder-side requests and the CPU-side clock/RDY outputs.
// Signals: hs_en, ls_req, div_sel (requests, decoder -> sequencer);
//          cpu_ck_phi2, rdy_drive_low, hs_sel, cycle_end (sequencer -> CPU side).
// Modports: master = request source / output observer, slave = sequencer.
interface clk_switch_seq_m_if
  import clksw_pkg::*;
#(
  parameter int DIV_LOG2_MAX = CLKSW_DIV_LOG2_MAX
);
  localparam int DIV_SEL_W = cnt_width(DIV_LOG2_MAX);

  logic                 hs_en;
  logic                 ls_req;
  logic [DIV_SEL_W-1:0] div_sel;
  logic                 cpu_ck_phi2;
  logic                 rdy_drive_low;
  logic                 hs_sel;
  logic                 cycle_end;

  modport master (
    output hs_en, ls_req, div_sel,
    input  cpu_ck_phi2, rdy_drive_low, hs_sel, cycle_end
  );

  modport slave (
    input  hs_en, ls_req, div_sel,
    output cpu_ck_phi2, rdy_drive_low, hs_sel, cycle_end
  );
endinterface

// File: rtl/sync_edge_m.sv
// rtl/sync_edge_m.sv - multi-flop synchroniser with rise/fall pulse generation
// Purpose: brings an asynchronous level into the clk domain and flags its edges.
// Ports: clk, reset (sync, active-high), d (async in),
//        level (synchronised d), rise/fall (one-cycle edge pulses of level).
module sync_edge_m #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Preset high so a level that is already high when reset lifts is never
  // mistaken for a fresh rise; a spurious fall is harmless to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/clk_switch_seq_m.sv
// rtl/clk_switch_seq_m.sv - glitch-free HS divider / LS phi0 tracker generating CPU phi2
// Purpose: produces a registered CPU phi2 either from a power-of-two divider of
//          hs_ck (HS mode) or tracking synchronised BBC phi0 (LS mode), switching
//          only at phi2 falls with a guaranteed low dead time.
// Ports: hs_ck (clock), reset (sync, active-high), bbc_ck2_phi0 (async phi0),
//        ctl (slave modport: hs_en, ls_req, div_sel in; cpu_ck_phi2,
//        rdy_drive_low, hs_sel, cycle_end out).
// Config: CLKSW_RDY_HOLD_EN - when defined, rdy_drive_low is held high from a
//         mode switch until the first phi2 fall in the new mode; otherwise 0.
module clk_switch_seq_m
  import clksw_pkg::*;
#(
  parameter int SYNC_STAGES  = CLKSW_SYNC_STAGES,
  parameter int DIV_LOG2_MAX = CLKSW_DIV_LOG2_MAX,
  parameter int DEADTIME     = CLKSW_DEADTIME
) (
  input  logic              hs_ck,
  input  logic              reset,
  input  logic              bbc_ck2_phi0,
  clk_switch_seq_m_if.slave ctl
);
`ifdef CLKSW_RDY_HOLD_EN
  localparam logic RDY_HOLD = 1'b1;
`else
  localparam logic RDY_HOLD = 1'b0;
`endif

  localparam int HCNT_W = (DIV_LOG2_MAX < 1) ? 1 : DIV_LOG2_MAX;
  localparam int DT_W   = cnt_width(DEADTIME);
  localparam logic [DT_W-1:0] DT_MAX  = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

  logic              phi0_s, phi0_rise, phi0_fall;
  clksw_state_e      state;
  logic [DT_W-1:0]   dt_cnt;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] h_last;   // latched half-period minus one
  logic [HCNT_W-1:0] h_next;
  logic              phi2_q, hs_sel_q, rdy_q, cycle_end_q;
  logic              enter_hs, leave_hs;

  sync_edge_m #(.STAGES(SYNC_STAGES)) u_phi0_sync (
    .clk   (hs_ck),
    .reset (reset),
    .d     (bbc_ck2_phi0),
    .level (phi0_s),
    .rise  (phi0_rise),
    .fall  (phi0_fall)
  );

  assign enter_hs = ctl.hs_en & ~ctl.ls_req;
  assign leave_hs = ~ctl.hs_en | ctl.ls_req;
  assign h_next   = HCNT_W'(half_period(int'(ctl.div_sel), DIV_LOG2_MAX) - 1);

  // Every phi2 fall latches the divider and makes the mode decision; rdy is
  // re-evaluated there too, so a switch sets it and a non-switching fall clears it.
  always_ff @(posedge hs_ck) begin
    if (reset) begin
      state       <= TO_LS;
      dt_cnt      <= '0;
      hcnt        <= '0;
      h_last      <= '0;
      phi2_q      <= 1'b0;
      hs_sel_q    <= 1'b0;
      rdy_q       <= 1'b0;
      cycle_end_q <= 1'b0;
    end else begin
      cycle_end_q <= 1'b0;
      case (state)
        TO_LS: begin
          phi2_q   <= 1'b0;
          hs_sel_q <= 1'b0;
          // Only a rise after the dead time counts; an early one is skipped.
          if (phi0_rise && dt_cnt >= DT_MAX) begin
            state  <= LS_RUN;
            phi2_q <= 1'b1;
          end else if (dt_cnt != DT_MAX) begin
            dt_cnt <= dt_cnt + 1'b1;
          end
        end
        LS_RUN: begin
          phi2_q <= phi0_s;
          if (phi0_fall) begin
            cycle_end_q <= 1'b1;
            h_last      <= h_next;
            rdy_q       <= RDY_HOLD & enter_hs;
            if (enter_hs) begin
              state  <= TO_HS;
              dt_cnt <= '0;
            end
          end
        end
        TO_HS: begin
          phi2_q <= 1'b0;
          if (dt_cnt == DT_LAST) begin
            state    <= HS_RUN;
            hs_sel_q <= 1'b1;
            hcnt     <= '0;   // first low phase is a full half-period
          end else begin
            dt_cnt <= dt_cnt + 1'b1;
          end
        end
        HS_RUN: begin
          if (hcnt == h_last) begin
            hcnt   <= '0;
            phi2_q <= ~phi2_q;
            if (phi2_q) begin
              cycle_end_q <= 1'b1;
              h_last      <= h_next;
              rdy_q       <= RDY_HOLD & leave_hs;
              if (leave_hs) begin
                state    <= TO_LS;
                hs_sel_q <= 1'b0;
                dt_cnt   <= '0;
              end
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= TO_LS;
      endcase
    end
  end

  assign ctl.cpu_ck_phi2   = phi2_q;
  assign ctl.rdy_drive_low = rdy_q;
  assign ctl.hs_sel        = hs_sel_q;
  assign ctl.cycle_end     = cycle_end_q;
endmodule

// File: tb/tb_clk_switch_seq_m.sv
// tb/tb_clk_switch_seq_m.sv - self-checking bench for clk_switch_seq_m
module tb_clk_switch_seq_m;
  import clksw_pkg::*;

  localparam int S   = 2;
  localparam int DLM = 3;
  localparam int DT  = 2;
  localparam int PH  = 6;   // phi0 half-period in hs_ck cycles
  localparam int NV  = 5;
`ifdef CLKSW_RDY_HOLD_EN
  localparam int RDY_EXP = 1;
`else
  localparam int RDY_EXP = 0;
`endif

  typedef struct {
    logic       hs_en;
    logic       ls_req;
    logic [1:0] div_sel;
    int         half;
  } vec_t;

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  logic hs_ck = 1'b0;
  logic reset = 1'b1;
  logic phi0  = 1'b1;
  int   cyc = 0;
  int   phi0_rise_cyc = -1000;
  int   phi0_fall_cyc = -1000;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t vecs[NV];

  int run_hi2 = 0, run_lo2 = 0, last_hi2 = 0, last_lo2 = 0;

  clk_switch_seq_m_if #(.DIV_LOG2_MAX(DLM)) bus ();
  clk_switch_seq_m_if #(.DIV_LOG2_MAX(2))   bus2 ();

  clk_switch_seq_m #(.SYNC_STAGES(S), .DIV_LOG2_MAX(DLM), .DEADTIME(DT)) dut (
    .hs_ck(hs_ck), .reset(reset), .bbc_ck2_phi0(phi0), .ctl(bus.slave));

  clk_switch_seq_m #(.SYNC_STAGES(S), .DIV_LOG2_MAX(2), .DEADTIME(DT)) dut2 (
    .hs_ck(hs_ck), .reset(reset), .bbc_ck2_phi0(phi0), .ctl(bus2.slave));

  always #5 hs_ck = ~hs_ck;
  always @(posedge hs_ck) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (PH) @(negedge hs_ck);
      #2;
      phi0 = ~phi0;
      if (phi0) phi0_rise_cyc = cyc;
      else      phi0_fall_cyc = cyc;
    end
  end

  // Run lengths of the second instance (divider exponent clamped to 2).
  always @(negedge hs_ck) begin
    if (bus2.cpu_ck_phi2 === 1'b1) begin
      run_hi2 <= run_hi2 + 1;
      if (run_lo2 > 0) last_lo2 <= run_lo2;
      run_lo2 <= 0;
    end else begin
      run_lo2 <= run_lo2 + 1;
      if (run_hi2 > 0) last_hi2 <= run_hi2;
      run_hi2 <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fall(input string name);
    int n = 0;
    do begin
      @(negedge hs_ck);
      n++;
    end while (bus.cycle_end !== 1'b1 && n < 200);
    if (bus.cycle_end !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: no cycle_end within %0d cycles, got 0, expected 1", name, n);
    end
  endtask

  task automatic low_run(output int n);
    n = 0;
    while (bus.cpu_ck_phi2 === 1'b0 && n < 200) begin
      n++;
      @(negedge hs_ck);
    end
  endtask

  task automatic high_run(output int n);
    n = 0;
    while (bus.cpu_ck_phi2 === 1'b1 && n < 200) begin
      n++;
      @(negedge hs_ck);
    end
  endtask

  task automatic run_period(input string name);
    exp_t e;
    int   lo, hi;
    low_run(lo);
    high_run(hi);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got period %0d/%0d, expected an entry", name, lo, hi);
    end else begin
      e = exp_q.pop_front();
      check({name, "_lo"}, lo, e.lo);
      check({name, "_hi"}, hi, e.hi);
    end
    check({name, "_hs_sel"}, bus.hs_sel, 1);
  endtask

  initial begin
    int lo, hi, rel, prev_h, n;
    vecs[0] = '{hs_en: 1'b1, ls_req: 1'b0, div_sel: 2'd3, half: 8};
    vecs[1] = '{hs_en: 1'b1, ls_req: 1'b0, div_sel: 2'd1, half: 2};
    vecs[2] = '{hs_en: 1'b1, ls_req: 1'b0, div_sel: 2'd2, half: 4};
    vecs[3] = '{hs_en: 1'b1, ls_req: 1'b0, div_sel: 2'd0, half: 1};
    vecs[4] = '{hs_en: 1'b1, ls_req: 1'b0, div_sel: 2'd3, half: 8};

    bus.hs_en = 1'b0; bus.ls_req = 1'b0; bus.div_sel = 2'd0;
    bus2.hs_en = 1'b1; bus2.ls_req = 1'b0; bus2.div_sel = 2'd3;

    // Reset held while phi0 is high.
    repeat (3) @(negedge hs_ck);
    check("rst_phi2", bus.cpu_ck_phi2, 0);
    check("rst_hs_sel", bus.hs_sel, 0);
    check("rst_rdy", bus.rdy_drive_low, 0);
    check("rst_cycle_end", bus.cycle_end, 0);
    reset = 1'b0;
    rel = cyc;

    low_run(lo);
    check("rst_rise_after_release", int'(phi0_rise_cyc > rel), 1);
    check("ls_rise_lag", cyc - phi0_rise_cyc, S + 1);
    check("ls_hs_sel", bus.hs_sel, 0);
    wait_fall("ls_first_fall");
    check("ls_fall_lag", cyc - phi0_fall_cyc, S + 1);

    // LS -> HS with div_sel=0.
    bus.hs_en = 1'b1;
    bus.div_sel = 2'd0;
    wait_fall("ls_to_hs");
    check("to_hs_rdy", bus.rdy_drive_low, RDY_EXP);
    check("to_hs_hs_sel", bus.hs_sel, 0);
    low_run(lo);
    high_run(hi);
    check("ls_hs_gap", lo, DT + 1);
    check("hs_first_high", hi, 1);
    check("hs_first_fall_ce", bus.cycle_end, 1);
    check("hs_first_fall_rdy", bus.rdy_drive_low, 0);
    check("hs_first_fall_hs_sel", bus.hs_sel, 1);

    // Divider table: new div_sel applies only after the next phi2 fall.
    prev_h = 1;
    for (int i = 0; i < NV; i++) begin
      bus.hs_en = vecs[i].hs_en;
      bus.ls_req = vecs[i].ls_req;
      bus.div_sel = vecs[i].div_sel;
      exp_q.push_back('{lo: prev_h, hi: prev_h});
      exp_q.push_back('{lo: vecs[i].half, hi: vecs[i].half});
      run_period($sformatf("vec%0d_old", i));
      run_period($sformatf("vec%0d_new", i));
      prev_h = vecs[i].half;
    end

    // ls_req pulsed mid-high, removed before the fall: no switch.
    low_run(lo);
    @(negedge hs_ck);
    bus.ls_req = 1'b1;
    repeat (2) @(negedge hs_ck);
    bus.ls_req = 1'b0;
    wait_fall("ls_pulse_fall");
    check("ls_pulse_hs_sel", bus.hs_sel, 1);
    low_run(lo);
    high_run(hi);
    check("ls_pulse_lo", lo, 8);
    check("ls_pulse_hi", hi, 8);

    // ls_req held through the fall: HS -> LS.
    bus.ls_req = 1'b1;
    wait_fall("hs_to_ls");
    check("to_ls_hs_sel", bus.hs_sel, 0);
    check("to_ls_rdy", bus.rdy_drive_low, RDY_EXP);
    low_run(lo);
    check("to_ls_deadtime", int'(lo >= DT), 1);
    check("to_ls_rise_lag", cyc - phi0_rise_cyc, S + 1);
    check("to_ls_rise_rdy", bus.rdy_drive_low, RDY_EXP);
    high_run(hi);
    check("to_ls_high", hi, PH);
    check("to_ls_fall_ce", bus.cycle_end, 1);
    check("to_ls_fall_rdy", bus.rdy_drive_low, 0);
    check("to_ls_fall_lag", cyc - phi0_fall_cyc, S + 1);

    // Reset while HS phi2 is high.
    bus.ls_req = 1'b0;
    wait_fall("ls_to_hs_again");
    low_run(lo);
    check("hs_again_gap", lo, DT + 8);
    @(negedge hs_ck);
    reset = 1'b1;
    @(negedge hs_ck);
    check("mid_rst_phi2", bus.cpu_ck_phi2, 0);
    check("mid_rst_hs_sel", bus.hs_sel, 0);
    check("mid_rst_ce", bus.cycle_end, 0);
    check("mid_rst_rdy", bus.rdy_drive_low, 0);
    bus.hs_en = 1'b0;
    n = 0;
    do begin
      @(negedge hs_ck);
      n++;
    end while (!(phi0 === 1'b0 && cyc == phi0_fall_cyc + 1) && n < 100);
    reset = 1'b0;
    rel = cyc;
    low_run(lo);
    check("mid_rst_rise_after_release", int'(phi0_rise_cyc > rel), 1);
    check("mid_rst_rise_lag", cyc - phi0_rise_cyc, S + 1);
    high_run(hi);
    check("mid_rst_first_high", hi, PH);

    // Clamped divider on the second instance: div_sel=3 with max exponent 2.
    repeat (80) @(negedge hs_ck);
    #1;
    check("clamp_high", last_hi2, 4);
    check("clamp_low", last_lo2, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
